mux_n_pipe: RTL and testbench

- Parametrised N-way operand select mux: the successor to the fixed 16-bit 2:1 datapath mux.
- Adds a registered output stage with a valid/ready handshake, an optional 2-entry skid buffer, select-range checking and an output transfer counter.
- Sits between the register file/immediate sources and the ALU/accumulator input, so the datapath can stall without losing operands.

---
 rtl/mux_n_pipe.sv | 101 ++++++++++
 tb/tb_mux_n_pipe.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way operand select with registered valid/ready output; define MUX_SKID_EN for a 2-entry skid buffer
module mux_n_pipe #(
  parameter int WIDTH   = 16,
  parameter int NUM_IN  = 4,
  parameter int SEL_W   = 2,
  parameter int COUNT_W = 8
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] In_Data,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [WIDTH-1:0]        Out_Data,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic                    Sel_Err,
  input  logic                    Err_Clear,
  output logic [COUNT_W-1:0]      Xfer_Count
);
  logic accept, take, sel_ok, load_main;
  logic [WIDTH-1:0] sel_word, main_d;
  assign accept = In_Valid & In_Ready;
  assign take   = Out_Valid & Out_Ready;
  // pick the addressed channel; an out-of-range select yields zero and flags sel_ok low
  always_comb begin
    sel_word = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_IN; k++)
      if (Sel == SEL_W'(k)) begin
        sel_word = In_Data[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
  end
`ifdef MUX_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic load_skid, from_skid;
  logic [WIDTH-1:0] skid;
  assign In_Ready  = state != TWO;
  assign Out_Valid = state != EMPTY;
  assign main_d    = from_skid ? skid : sel_word;
  // occupancy tracking: second word parks in skid while the output stalls
  always_comb begin
    state_n   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_n   = ONE;
        load_main = 1'b1;
      end
      ONE: if (accept && take) load_main = 1'b1;
        else if (accept) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end
        else if (take) state_n = EMPTY;
      TWO: if (take) begin
        state_n   = ONE;
        load_main = 1'b1;
        from_skid = 1'b1;
      end
      default: state_n = EMPTY;
    endcase
  end
  // skid register holds the queued second word
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) skid <= '0;
    else if (load_skid) skid <= sel_word;
`else
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_n;
  assign In_Ready  = !Out_Valid | Out_Ready;
  assign Out_Valid = state != EMPTY;
  assign main_d    = sel_word;
  // single register: any accept loads it, a lone take empties it
  always_comb begin
    load_main = accept;
    state_n   = accept ? FULL : take ? EMPTY : state;
  end
`endif
  // state register
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) state <= EMPTY;
    else state <= state_n;
  // output register, held while stalled
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) Out_Data <= '0;
    else if (load_main) Out_Data <= main_d;
  // sticky select error; a new bad select beats a clear in the same cycle
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) Sel_Err <= 1'b0;
    else if (accept && !sel_ok) Sel_Err <= 1'b1;
    else if (Err_Clear) Sel_Err <= 1'b0;
  // count completed output handshakes, wrapping naturally
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) Xfer_Count <= '0;
    else if (take) Xfer_Count <= Xfer_Count + 1'b1;
endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed checks of mux_n_pipe (default build and NUM_IN=3 instance)
module tb_mux_n_pipe;
`ifdef MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [63:0] in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  logic [47:0] in_data3 = {16'h3333, 16'h2222, 16'h1111};
  logic [1:0] sel = '0, sel3 = '0;
  logic in_valid = 1'b0, out_ready = 1'b0, err_clear = 1'b0;
  logic in_valid3 = 1'b0, out_ready3 = 1'b0, err_clear3 = 1'b0;
  logic in_ready, out_valid, sel_err, in_ready3, out_valid3, sel_err3;
  logic [15:0] out_data, out_data3;
  logic [7:0] xfer_count, xfer_count3;
  int n_checks = 0, n_pass = 0;
  always #5 clk = ~clk;
  mux_n_pipe dut (
    .CLK(clk), .Reset(rst), .In_Data(in_data), .Sel(sel), .In_Valid(in_valid),
    .In_Ready(in_ready), .Out_Data(out_data), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Sel_Err(sel_err), .Err_Clear(err_clear), .Xfer_Count(xfer_count)
  );
  mux_n_pipe #(.NUM_IN(3)) dut3 (
    .CLK(clk), .Reset(rst), .In_Data(in_data3), .Sel(sel3), .In_Valid(in_valid3),
    .In_Ready(in_ready3), .Out_Data(out_data3), .Out_Valid(out_valid3), .Out_Ready(out_ready3),
    .Sel_Err(sel_err3), .Err_Clear(err_clear3), .Xfer_Count(xfer_count3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  initial begin
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", out_valid, 0);
    check("idle_data", out_data, 0);
    check("idle_ready", in_ready, 1);
    check("idle_count", xfer_count, 0);
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
    @(negedge clk);
    check("stream0", out_data, 16'h3333);
    check("stream0_v", out_valid, 1);
    sel = 2'd0;
    @(negedge clk);
    check("stream1", out_data, 16'h1111);
    sel = 2'd3;
    @(negedge clk);
    check("stream2", out_data, 16'h4444);
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_end_v", out_valid, 0);
    check("stream_count", xfer_count, 3);
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    check("stall_rdy0", in_ready, 1);
    @(negedge clk);
    check("stall_d0", out_data, 16'h2222);
    check("stall_rdy1", in_ready, SKID);
    sel = 2'd3;
    @(negedge clk);
    check("stall_rdy2", in_ready, 0);
    check("stall_hold", out_data, 16'h2222);
    check("stall_hold_v", out_valid, 1);
    sel = SKID ? 2'd0 : 2'd3;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain1", out_data, 16'h4444);
    sel = 2'd0;
    @(negedge clk);
    check("drain2", out_data, 16'h1111);
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_end_v", out_valid, 0);
    check("drain_count", xfer_count, 6);
    out_ready3 = 1'b1; in_valid3 = 1'b1; sel3 = 2'd3;
    @(negedge clk);
    check("bad_data", out_data3, 0);
    check("bad_valid", out_valid3, 1);
    check("bad_err", sel_err3, 1);
    sel3 = 2'd2;
    @(negedge clk);
    check("good3_data", out_data3, 16'h3333);
    check("err_sticky", sel_err3, 1);
    sel3 = 2'd3; err_clear3 = 1'b1;
    @(negedge clk);
    check("err_set_wins", sel_err3, 1);
    in_valid3 = 1'b0;
    @(negedge clk);
    check("err_cleared", sel_err3, 0);
    err_clear3 = 1'b0; in_valid3 = 1'b1; sel3 = 2'd1;
    @(negedge clk);
    check("good3_data1", out_data3, 16'h2222);
    check("good3_noerr", sel_err3, 0);
    in_valid3 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wrap_start", xfer_count, 0);
    in_valid = 1'b1; sel = 2'd1;
    repeat (256) @(negedge clk);
    check("wrap_255", xfer_count, 255);
    @(negedge clk);
    check("wrap_0", xfer_count, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_1", xfer_count, 1);
    check("wrap_end_v", out_valid, 0);
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
    out_ready3 = 1'b0; in_valid3 = 1'b1; sel3 = 2'd3;
    @(negedge clk);
    @(negedge clk);
    check("fill_rdy", in_ready, 0);
    check("fill_err3", sel_err3, 1);
    in_valid = 1'b0; in_valid3 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_v", out_valid, 0);
    check("async_d", out_data, 0);
    check("async_rdy", in_ready, 1);
    check("async_err3", sel_err3, 0);
    check("async_v3", out_valid3, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_v", out_valid, 0);
    check("post_rst_rdy", in_ready, 1);
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd0;
    @(negedge clk);
    check("post_rst_d", out_data, 16'h1111);
    check("post_rst_dv", out_valid, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_once", out_valid, 0);
    check("post_rst_cnt", xfer_count, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
